// File: rtl/ndma_pkg.sv
// Shared types and default widths for the NDMA burst read manager.
package ndma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int NDMA_ADDR_W     = 32;
    localparam int NDMA_DATA_W     = 32;
    localparam int NDMA_LEN_W      = 8;
    localparam int NDMA_MAX_OUTST  = 2;
    localparam int NDMA_FIFO_DEPTH = 4;

endpackage

// File: rtl/ndma_fifo.sv
// Read-data buffer between the OBI response channel and the output stream.
module ndma_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  logic [DATA_W-1:0]             data_i,
    input  logic                          pop_i,
    output logic [DATA_W-1:0]             data_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              full;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        full    = (count_q == CNT_W'(FIFO_DEPTH));
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && (!full || do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/ndma_burst_read_mgr.sv
// OBI burst read engine: issues up to MAX_OUTST reads under FIFO credit and streams the data out.
module ndma_burst_read_mgr
    import ndma_pkg::*;
#(
    parameter int ADDR_W     = NDMA_ADDR_W,
    parameter int DATA_W     = NDMA_DATA_W,
    parameter int LEN_W      = NDMA_LEN_W,
    parameter int MAX_OUTST  = NDMA_MAX_OUTST,
    parameter int FIFO_DEPTH = NDMA_FIFO_DEPTH
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [LEN_W-1:0]    len_i,
    input  logic                incr_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic                rvalid_o,
    output logic [DATA_W-1:0]   rdata_o,
    input  logic                rready_i,
    output logic                obi_req_o,
    input  logic                obi_gnt_i,
    output logic [ADDR_W-1:0]   obi_addr_o,
    output logic                obi_we_o,
    output logic [DATA_W/8-1:0] obi_be_o,
    output logic [DATA_W-1:0]   obi_wdata_o,
    input  logic                obi_rvalid_i,
    input  logic [DATA_W-1:0]   obi_rdata_i,
    input  logic                obi_err_i
);

    localparam int OUT_W = $clog2(MAX_OUTST + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CRD_W = $clog2(FIFO_DEPTH + MAX_OUTST + 1) + 1;

    state_t            state_q;
    logic [OUT_W-1:0]  outst_q;
    logic [LEN_W-1:0]  req_rem_q;
    logic [LEN_W-1:0]  rsp_rem_q;
    logic [ADDR_W-1:0] addr_q;
    logic              incr_q;
    logic              err_q;
    logic              done_q;

    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_empty;
    logic              can_req;
    logic              gnt;
    logic              rsp;
    logic              last_rsp;
    logic              pop;

    // Outstanding reads count against FIFO space so a response always has a slot.
    always_comb begin
        can_req  = (state_q == RUN)
                && (outst_q < OUT_W'(MAX_OUTST))
                && ((CRD_W'(outst_q) + CRD_W'(fifo_cnt)) < CRD_W'(FIFO_DEPTH))
                && (req_rem_q != '0);
        gnt      = can_req && obi_gnt_i;
        rsp      = obi_rvalid_i && (outst_q != '0);
        last_rsp = rsp && (rsp_rem_q == LEN_W'(1));
        pop      = !fifo_empty && rready_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            outst_q   <= '0;
            req_rem_q <= '0;
            rsp_rem_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        err_q <= 1'b0;
                        if (len_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q   <= RUN;
                            req_rem_q <= len_i;
                            rsp_rem_q <= len_i;
                        end
                    end
                end
                RUN: begin
                    if (gnt && (req_rem_q == LEN_W'(1))) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (last_rsp) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (gnt)               req_rem_q <= req_rem_q - LEN_W'(1);
            if (rsp)               rsp_rem_q <= rsp_rem_q - LEN_W'(1);
            if (rsp && obi_err_i)  err_q     <= 1'b1;
            case ({gnt, rsp})
                2'b10:   outst_q <= outst_q + OUT_W'(1);
                2'b01:   outst_q <= outst_q - OUT_W'(1);
                default: outst_q <= outst_q;
            endcase
        end
    end

    // Address path: only meaningful while a request is up, so no reset.
    always_ff @(posedge clk_i) begin
        if ((state_q == IDLE) && start_i) begin
            addr_q <= addr_i;
            incr_q <= incr_i;
        end else if (gnt && incr_q) begin
            addr_q <= addr_q + ADDR_W'(DATA_W / 8);
        end
    end

    ndma_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rsp),
        .data_i  (obi_rdata_i),
        .pop_i   (pop),
        .data_o  (rdata_o),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rvalid_o    = !fifo_empty;
    assign obi_req_o   = can_req;
    assign obi_addr_o  = addr_q;
    assign obi_we_o    = 1'b0;
    assign obi_be_o    = '1;
    assign obi_wdata_o = '0;

endmodule

// File: tb/tb_ndma_burst_read_mgr.sv
// Directed bench for ndma_burst_read_mgr with an in-order OBI slave model.
module tb_ndma_burst_read_mgr;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [7:0]  len_i = '0;
    logic        incr_i = 1'b1;
    logic        rready_i = 1'b1;
    wire         busy_o, done_o, err_o, rvalid_o;
    wire  [31:0] rdata_o;
    wire         obi_req_o, obi_we_o, obi_gnt_i;
    wire  [31:0] obi_addr_o, obi_wdata_o;
    wire  [3:0]  obi_be_o;
    logic        obi_rvalid_i = 1'b0;
    logic [31:0] obi_rdata_i = '0;
    logic        obi_err_i = 1'b0;

    logic        delay_mode = 1'b0;
    int          err_word = 99;
    int          sl_idx = 0;
    int          stall_n = 0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic [31:0] addr_log[$];
    int          addr_cyc[$];
    logic [31:0] stall_addr[$];
    int          stall_cyc[$];
    logic [31:0] out_log[$];
    int          done_cnt = 0;
    int          start_cyc = 0;

    ndma_burst_read_mgr dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .addr_i       (addr_i),
        .len_i        (len_i),
        .incr_i       (incr_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .rready_i     (rready_i),
        .obi_req_o    (obi_req_o),
        .obi_gnt_i    (obi_gnt_i),
        .obi_addr_o   (obi_addr_o),
        .obi_we_o     (obi_we_o),
        .obi_be_o     (obi_be_o),
        .obi_wdata_o  (obi_wdata_o),
        .obi_rvalid_i (obi_rvalid_i),
        .obi_rdata_i  (obi_rdata_i),
        .obi_err_i    (obi_err_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Zero-wait slave, optionally holding off the second grant for 3 cycles.
    assign obi_gnt_i = obi_req_o && !(delay_mode && (sl_idx == 1) && (stall_n < 3));

    always @(posedge clk_i) begin
        obi_rvalid_i <= obi_req_o && obi_gnt_i;
        obi_rdata_i  <= 32'hCAFE_0000 + 32'(sl_idx);
        obi_err_i    <= obi_req_o && obi_gnt_i && (sl_idx == err_word);
        if (start_i) begin
            sl_idx  <= 0;
            stall_n <= 0;
        end else begin
            if (obi_req_o && obi_gnt_i)  sl_idx  <= sl_idx + 1;
            if (obi_req_o && !obi_gnt_i) stall_n <= stall_n + 1;
        end
    end

    always @(negedge clk_i) begin
        if (start_i) begin
            addr_log.delete();
            addr_cyc.delete();
            stall_addr.delete();
            stall_cyc.delete();
            out_log.delete();
            done_cnt  = 0;
            start_cyc = cyc;
        end
        if (obi_req_o && obi_gnt_i) begin
            addr_log.push_back(obi_addr_o);
            addr_cyc.push_back(cyc);
        end
        if (obi_req_o && !obi_gnt_i) begin
            stall_addr.push_back(obi_addr_o);
            stall_cyc.push_back(cyc);
        end
        if (rvalid_o && rready_i) out_log.push_back(rdata_o);
        if (done_o) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic smp();
        @(negedge clk_i);
        #1;
    endtask

    task automatic start_burst(input logic [31:0] a, input int l, input logic inc);
        step(1);
        start_i = 1'b1;
        addr_i  = a;
        len_i   = l[7:0];
        incr_i  = inc;
        step(1);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            smp();
            if (!busy_o && !rvalid_o) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        step(3);
        rst_i = 1'b0;
        smp();
        check("rst_busy",   32'(busy_o),    32'd0);
        check("rst_done",   32'(done_o),    32'd0);
        check("rst_err",    32'(err_o),     32'd0);
        check("rst_req",    32'(obi_req_o), 32'd0);
        check("rst_rvalid", 32'(rvalid_o),  32'd0);

        // Incrementing burst of 4 from 0x1000
        start_burst(32'h1000, 4, 1'b1);
        wait_idle("inc_idle", 40);
        check("inc_ngnt", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("inc_addr", (addr_log.size() > i) ? addr_log[i] : 32'hDEAD_DEAD, 32'h1000 + 32'(4 * i));
        check("inc_first_lat", (addr_cyc.size() > 0) ? 32'(addr_cyc[0] - start_cyc) : 32'hFFFF, 32'd1);
        check("inc_b2b", (addr_cyc.size() > 3) ? 32'(addr_cyc[3] - addr_cyc[0]) : 32'hFFFF, 32'd3);
        check("inc_nout", 32'(out_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("inc_data", (out_log.size() > i) ? out_log[i] : 32'hDEAD_DEAD, 32'hCAFE_0000 + 32'(i));
        check("inc_done_cnt", 32'(done_cnt), 32'd1);
        check("inc_err", 32'(err_o), 32'd0);

        // Fixed-address burst
        start_burst(32'h2000, 3, 1'b0);
        wait_idle("fix_idle", 40);
        check("fix_ngnt", 32'(addr_log.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check("fix_addr", (addr_log.size() > i) ? addr_log[i] : 32'hDEAD_DEAD, 32'h2000);

        // Back-pressure: credit limits grants to the FIFO depth
        rready_i = 1'b0;
        start_burst(32'h4000, 8, 1'b1);
        step(15);
        smp();
        check("bp_ngnt",   32'(addr_log.size()), 32'd4);
        check("bp_req",    32'(obi_req_o), 32'd0);
        check("bp_rvalid", 32'(rvalid_o),  32'd1);
        check("bp_busy",   32'(busy_o),    32'd1);
        step(1);
        rready_i = 1'b1;
        wait_idle("bp_idle", 60);
        check("bp_ngnt_all", 32'(addr_log.size()), 32'd8);
        check("bp_nout", 32'(out_log.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check("bp_data", (out_log.size() > i) ? out_log[i] : 32'hDEAD_DEAD, 32'hCAFE_0000 + 32'(i));
        check("bp_done_cnt", 32'(done_cnt), 32'd1);

        // Grant held off 3 cycles on the second request
        delay_mode = 1'b1;
        start_burst(32'h3000, 4, 1'b1);
        wait_idle("dly_idle", 40);
        delay_mode = 1'b0;
        check("dly_nstall", 32'(stall_addr.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check("dly_stall_addr", (stall_addr.size() > i) ? stall_addr[i] : 32'hDEAD_DEAD, 32'h3004);
        check("dly_stall_span", (stall_cyc.size() > 2) ? 32'(stall_cyc[2] - stall_cyc[0]) : 32'hFFFF, 32'd2);
        check("dly_addr1", (addr_log.size() > 1) ? addr_log[1] : 32'hDEAD_DEAD, 32'h3004);
        check("dly_addr3", (addr_log.size() > 3) ? addr_log[3] : 32'hDEAD_DEAD, 32'h300C);
        check("dly_nout", 32'(out_log.size()), 32'd4);

        // Zero-length start
        start_burst(32'h7000, 0, 1'b1);
        smp();
        check("zl_done", 32'(done_o),    32'd1);
        check("zl_busy", 32'(busy_o),    32'd0);
        check("zl_req",  32'(obi_req_o), 32'd0);
        step(3);
        smp();
        check("zl_done_cnt", 32'(done_cnt), 32'd1);
        check("zl_ngnt", 32'(addr_log.size()), 32'd0);
        check("zl_done_low", 32'(done_o), 32'd0);

        // Error on word 2 of 4, cleared by the next start
        err_word = 1;
        start_burst(32'h5000, 4, 1'b1);
        wait_idle("err_idle", 40);
        check("err_set",  32'(err_o), 32'd1);
        check("err_nout", 32'(out_log.size()), 32'd4);
        check("err_data1", (out_log.size() > 1) ? out_log[1] : 32'hDEAD_DEAD, 32'hCAFE_0001);
        step(3);
        smp();
        check("err_sticky", 32'(err_o), 32'd1);
        err_word = 99;
        start_burst(32'h5100, 1, 1'b1);
        smp();
        check("err_clear", 32'(err_o), 32'd0);
        wait_idle("err2_idle", 40);

        // Reset in the middle of a burst
        rready_i = 1'b0;
        start_burst(32'h6000, 8, 1'b1);
        step(2);
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        smp();
        check("mrst_busy",   32'(busy_o),    32'd0);
        check("mrst_req",    32'(obi_req_o), 32'd0);
        check("mrst_rvalid", 32'(rvalid_o),  32'd0);
        step(3);
        smp();
        check("mrst_rvalid_late", 32'(rvalid_o), 32'd0);
        check("mrst_busy_late",   32'(busy_o),   32'd0);
        rready_i = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ndma_burst_read_mgr.md
NDMA_BURST_READ_MGR -- requirements
Module: ndma_burst_read_mgr

Interface
REQ-001 Parameter ADDR_W, default 32: OBI address width.
REQ-002 Parameter DATA_W, default 32: OBI and stream data width; a multiple of 8.
REQ-003 Parameter LEN_W, default 8: burst length counter width, in words.
REQ-004 Parameter MAX_OUTST, default 2: maximum granted-but-unanswered reads.
REQ-005 Parameter FIFO_DEPTH, default 4: read-data buffer entries; a power of two, >= MAX_OUTST.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high.
REQ-007 clk_i  in  1  clock.
REQ-008 rst_i  in  1  synchronous active-high reset.
REQ-009 start_i  in  1  burst start strobe; sampled only in IDLE.
REQ-010 addr_i  in  ADDR_W  first word address, captured on start.
REQ-011 len_i  in  LEN_W  number of words in the burst.
REQ-012 incr_i  in  1  1: address increments by DATA_W/8 per word; 0: address is fixed (peripheral FIFO mode).
REQ-013 busy_o  out  1  burst in progress.
REQ-014 done_o  out  1  one-cycle pulse at burst end.
REQ-015 err_o  out  1  sticky: an OBI error occurred in the current or last burst.
REQ-016 rvalid_o  out  1  stream data valid.
REQ-017 rdata_o  out  DATA_W  stream data.
REQ-018 rready_i  in  1  stream consumer ready.
REQ-019 obi_req_o  out  1  OBI request.
REQ-020 obi_gnt_i  in  1  OBI grant.
REQ-021 obi_addr_o  out  ADDR_W  OBI address.
REQ-022 obi_we_o  out  1  tied to 0.
REQ-023 obi_be_o  out  DATA_W/8  tied to all-ones.
REQ-024 obi_wdata_o  out  DATA_W  tied to 0.
REQ-025 obi_rvalid_i  in  1  OBI response valid.
REQ-026 obi_rdata_i  in  DATA_W  OBI response data.
REQ-027 obi_err_i  in  1  OBI response error.

Function
REQ-028 FSM states are IDLE, RUN and DRAIN.
- IDLE -> RUN on start_i with len_i > 0.
- RUN -> DRAIN when the last address is granted.
- DRAIN -> IDLE when the last response is received.
REQ-029 A start with len_i == 0 shall issue no request, pulse done_o in the next cycle, and stay in IDLE.
REQ-030 busy_o shall be 1 in RUN and DRAIN, and 0 in IDLE.
REQ-031 start_i while busy_o is 1 shall be ignored.
REQ-032 In RUN, obi_req_o shall be asserted only when all of the following hold:
- outstanding < MAX_OUTST;
- outstanding + FIFO count < FIFO_DEPTH (credit rule);
- words remain to be requested.
REQ-033 Once asserted, obi_req_o and obi_addr_o shall hold stable until obi_gnt_i is 1.
REQ-034 Back-to-back requests are allowed: a grant and a new request may occur in the same cycle.
REQ-035 On each grant, the address advances by DATA_W/8 if incr is 1, wrapping modulo 2^ADDR_W, and the outstanding count increments.
REQ-036 On each obi_rvalid_i, obi_rdata_i is pushed into the FIFO and the outstanding count decrements.
REQ-037 A grant and a response in the same cycle shall leave the outstanding count unchanged.
REQ-038 Responses are in order; the FIFO shall never overflow, guaranteed by the credit rule.
REQ-039 rvalid_o = FIFO not empty; rdata_o = FIFO head; the head pops on rvalid_o & rready_i.
REQ-040 Push and pop in the same cycle shall be allowed when the FIFO is full or empty.
REQ-041 done_o shall pulse in the cycle after the last response; the FIFO may still hold data after done_o.
REQ-042 obi_err_i with obi_rvalid_i shall set err_o and the data is still pushed; err_o clears on an accepted start.
REQ-043 Read latency: first request in the cycle after start; a zero-wait-state slave sustains one word per cycle when MAX_OUTST >= 2.

Reset
REQ-044 While rst_i is high at a clock edge, the block shall return to IDLE with:
- outstanding count, remaining count and FIFO cleared;
- busy_o, done_o, err_o, obi_req_o and rvalid_o all 0.
REQ-045 Reset mid-burst shall abandon the burst; responses arriving after reset shall be discarded.

Structure
REQ-046 Package ndma_pkg shall hold the state_t typedef (IDLE, RUN, DRAIN) and the default width constants.
REQ-047 The read-data buffer shall be the sub-module ndma_fifo, parametrised by DATA_W and FIFO_DEPTH.

Verification
REQ-048 Zero-wait slave, addr 0x1000, len 4, incr 1, rready_i = 1:
- addresses are 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles;
- 4 words stream out in order;
- done_o fires once.
REQ-049 incr 0, len 3, addr 0x2000: all three requests use address 0x2000.
REQ-050 rready_i held at 0, len 8, FIFO_DEPTH 4:
- exactly 4 grants occur, then obi_req_o stays 0;
- releasing rready_i completes all 8 words with no loss.
REQ-051 Slave delays gnt by 3 cycles on the second request: obi_req_o and obi_addr_o stay stable for all 3 cycles.
REQ-052 len 0: no obi_req_o, done_o pulses one cycle after start, busy_o stays 0.
REQ-053 err_i asserted on word 2 of 4: err_o sets and stays set, 4 words are delivered, a new start clears err_o.
